// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default frame geometry and parity encodings.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  localparam int DEFAULT_OVERSAMPLE = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit tick counter and 3-sample majority voter around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int TICK_W     = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load_one,
  input  logic              rx_in,
  output logic [TICK_W-1:0] tick,
  output logic              bit_end,
  output logic              sampled_bit
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SAMPLE_0  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] SAMPLE_1  = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] SAMPLE_2  = TICK_W'(OVERSAMPLE / 2 + 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        samples_q, samples_d;

  always_comb begin
    tick_d    = '0;
    samples_d = samples_q;
    if (load_one) begin
      tick_d = TICK_W'(1);
    end else if (enable && (tick_q != LAST_TICK)) begin
      tick_d = tick_q + TICK_W'(1);
    end
    if (enable) begin
      if (tick_q == SAMPLE_0) samples_d[0] = rx_in;
      if (tick_q == SAMPLE_1) samples_d[1] = rx_in;
      if (tick_q == SAMPLE_2) samples_d[2] = rx_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q    <= '0;
      samples_q <= '0;
    end else begin
      tick_q    <= tick_d;
      samples_q <= samples_d;
    end
  end

  assign tick        = tick_q;
  assign bit_end     = (tick_q == LAST_TICK);
  assign sampled_bit = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                       (samples_q[1] & samples_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, data shift register, parity check and registered output strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [TICK_W-1:0] VOTE_TICK = TICK_W'(OVERSAMPLE / 2 + 2);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_err_q, par_err_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  busy_q, busy_d;

  logic              enable, load_one;
  logic [TICK_W-1:0] tick;
  logic              bit_end, sampled_bit, bit_done;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .TICK_W     (TICK_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load_one    (load_one),
    .rx_in       (rx_in),
    .tick        (tick),
    .bit_end     (bit_end),
    .sampled_bit (sampled_bit)
  );

  // The vote is only trusted once all three centre samples have been captured.
  assign bit_done = bit_end && (tick >= VOTE_TICK);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_err_d  = par_err_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    enable     = (state_q != IDLE);
    load_one   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d    = START;
          load_one   = 1'b1;
          par_en_d   = parity_en;
          par_type_d = parity_type;
          par_err_d  = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = sampled_bit ? IDLE : DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = par_en_q ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_err_d = sampled_bit ^ (^shift_q) ^ (par_type_q == PARITY_ODD);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (sampled_bit && !par_err_q) begin
            valid_d    = 1'b1;
            data_out_d = shift_q;
          end else begin
            serr_d = !sampled_bit;
            perr_d = par_err_q;
          end
          // A low line here is the next frame's start bit arriving with no idle gap.
          if (!rx_in) begin
            state_d    = START;
            load_one   = 1'b1;
            par_en_d   = parity_en;
            par_type_d = parity_type;
            par_err_d  = 1'b0;
            bit_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || valid_d || perr_d || serr_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_err_q  <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_err_q  <= par_err_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = valid_q;
  assign parity_error = perr_q;
  assign stop_error   = serr_q;
  assign busy         = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link; the receive-side counterpart to the transmit FSM.
- Recovers frames of the form start(0), DATA_WIDTH data bits LSB first, optional parity bit, stop(1) from an oversampled serial line.
- Presents each received byte on a parallel port with a one-cycle valid strobe and per-frame error flags.
- Sits between the line interface and the receive-side consumer.
- Frame format and parity configuration match the transmitter, so the pair loops back directly.

## Interface
Parameters:
- OVERSAMPLE, 8: clock ticks per bit. Must be even and ≥ 6.
- DATA_WIDTH, 8: data bits per frame.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line, idle high.
  - Synchronous to clk; no synchronizer inside this block.
- parity_en  input  1  1 = a parity bit follows the data bits. Sampled at start-bit detection.
- parity_type  input  1  0 = even, 1 = odd. Sampled at start-bit detection.
- data_out  output  DATA_WIDTH  last good received word. Held until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- parity_error  output  1  one-cycle pulse at end of frame on parity mismatch.
- stop_error  output  1  one-cycle pulse at end of frame when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

## Operation
- Reset: all outputs 0, state IDLE, counters 0, shift register 0.
- tick (edge counter), 0..OVERSAMPLE-1:
  - On detection, tick loads 1; the detection cycle counts as tick 0 of the start bit.
  - tick wraps after OVERSAMPLE-1, and bit_cnt advances on the wrap.
- Bit sample: majority of 3 samples taken at tick = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The majority is valid from tick OVERSAMPLE/2+2.
- States:
  - IDLE: rx_in==0 → START. Latch parity_en and parity_type.
  - START: at tick OVERSAMPLE-1, majority 0 → DATA; majority 1 (glitch) → IDLE with no output pulses.
  - DATA: at each bit's last tick, shift the majority in LSB first. After DATA_WIDTH bits → PARITY if parity_en, else STOP.
  - PARITY: compute the expected parity bit as XOR of the data bits (even); for odd parity, the inverse. At the last tick → STOP; hold mismatch internally.
  - STOP: at the last tick, evaluate the stop-bit majority and the parity mismatch:
    - Both good: load data_out and pulse data_valid.
    - Any error: pulse the matching error flag(s); data_out unchanged, data_valid stays 0.
    - Next state: START (tick loads 1) if rx_in==0 in that same cycle, else IDLE. This handles back-to-back frames with no idle gap.
- Parity and stop errors can pulse in the same cycle.
- parity_en and parity_type changing mid-frame have no effect.
- Reset mid-frame returns to IDLE immediately; no pulses are generated.

## Timing
- Cycle 0 = the clk edge at which IDLE sees rx_in==0. N = 10 + parity_en.
- Bit k, tick i occurs at cycle k·OVERSAMPLE + i.
- Output pulses (data_valid / errors) are registered and high during cycle N·OVERSAMPLE, exactly one cycle wide.
  - OVERSAMPLE=8: cycle 80 without parity, cycle 88 with parity.
- busy: high from cycle 1 through cycle N·OVERSAMPLE.
  - Drops the cycle after if the next state is IDLE.
  - Stays high on a back-to-back start.
- Tolerates ±(OVERSAMPLE/2-2) ticks of cumulative bit-edge drift over a frame.

## Structure
- Package uart_pkg:
  - Shared rx/tx state localparams (IDLE, START, DATA, PARITY, STOP as 3-bit codes).
  - Default OVERSAMPLE and DATA_WIDTH.
  - Parity-type encodings.
- Sub-module uart_rx_sampler:
  - Contains the tick counter and 3-sample majority voter.
  - Outputs tick, bit_end (tick==OVERSAMPLE-1) and sampled_bit.
  - Controlled by an enable and a load-1 input from the FSM.
- The top level holds the FSM, bit_cnt, shift register, parity check and output registers.

## Test plan
- No parity, OVERSAMPLE=8, send 0xA5 → data_valid high only at cycle 80, data_out=0xA5, no error pulses, busy low at cycle 81.
- parity_en=1, even, send 0x3C with parity bit 0 → data_valid at cycle 88, data_out=0x3C. Same frame with parity bit 1 → parity_error pulse at cycle 88, data_out keeps 0xA5.
- Stop bit driven 0 on 0x5A → stop_error pulse at cycle 80, data_valid stays 0. Driving the parity bit wrong as well in a parity frame → both error flags pulse together.
- rx_in low for 3 cycles then high → return to IDLE at cycle 8, busy low from cycle 8, no output pulses.
- Frames 0x01 then 0xFE with no idle gap → two data_valid pulses exactly 80 cycles apart, busy never drops between them.
- rst asserted at cycle 40 of a frame → all outputs 0 immediately. The next clean frame 0x77 after reset release → data_valid with data_out=0x77.
